// File: rtl/tl_memory_pkg.sv
// Shared definitions for the MEM stage: control-bus bit positions, access-size encodings
// and the alignment rule used by both the store and load paths.
package tl_memory_pkg;

    // ctrl_mem bit positions
    localparam int MEMREAD  = 8;
    localparam int MEMWRITE = 7;
    localparam int BEQ      = 6;
    localparam int BNE      = 5;
    localparam int SIZE_HI  = 4;
    localparam int SIZE_LO  = 3;
    localparam int UNSIGNED = 2;

    // ctrl_wb bit positions
    localparam int WB_REGWRITE = 1;
    localparam int WB_MEMTOREG = 0;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_RSVD = 2'b10,
        SZ_WORD = 2'b11
    } size_e;

    // Reserved size encoding behaves as a word access.
    function automatic logic is_misaligned(input size_e sz, input logic [1:0] lane);
        case (sz)
            SZ_BYTE: return 1'b0;
            SZ_HALF: return lane[0];
            default: return |lane;
        endcase
    endfunction

endpackage

// File: rtl/tl_memory_if.sv
// EX/MEM inputs and MEM/WB outputs of the MEM stage, named from the MEM stage's point of view.
interface tl_memory_if #(
    parameter int LEN                  = 32,
    parameter int NB_ADDRESS_REGISTROS = 5,
    parameter int NB_CTRL_WB           = 2,
    parameter int NB_CTRL_MEM          = 9
);
    logic [LEN-1:0]                  i_alu_result;
    logic [LEN-1:0]                  i_dato2;
    logic [LEN-1:0]                  i_pc_branch;
    logic                            i_alu_zero;
    logic [NB_ADDRESS_REGISTROS-1:0] i_write_reg;
    logic [NB_CTRL_WB-1:0]           i_ctrl_wb;
    logic [NB_CTRL_MEM-1:0]          i_ctrl_mem;

    logic                            o_pc_src;
    logic [LEN-1:0]                  o_pc_branch;
    logic [LEN-1:0]                  o_rd_mem_corto;
    logic [LEN-1:0]                  o_read_data;
    logic [LEN-1:0]                  o_alu_result;
    logic [NB_ADDRESS_REGISTROS-1:0] o_write_reg;
    logic [NB_CTRL_WB-1:0]           o_ctrl_wb;
    logic                            o_misaligned;

    modport slave (
        input  i_alu_result, i_dato2, i_pc_branch, i_alu_zero, i_write_reg, i_ctrl_wb, i_ctrl_mem,
        output o_pc_src, o_pc_branch, o_rd_mem_corto, o_read_data, o_alu_result, o_write_reg,
               o_ctrl_wb, o_misaligned
    );

    modport master (
        output i_alu_result, i_dato2, i_pc_branch, i_alu_zero, i_write_reg, i_ctrl_wb, i_ctrl_mem,
        input  o_pc_src, o_pc_branch, o_rd_mem_corto, o_read_data, o_alu_result, o_write_reg,
               o_ctrl_wb, o_misaligned
    );

endinterface

// File: rtl/tl_memory_data_memory.sv
// Data RAM with one byte-wide array per lane, per-lane write enables and asynchronous read.
// DMEM_DEBUG_PORT_EN adds an independent asynchronous word-read port for the debug unit.
module data_memory #(
    parameter int LEN          = 32,
    parameter int NB_DMEM_ADDR = 8
) (
    input  logic                    i_clk,
    input  logic [LEN/8-1:0]        i_we,
    input  logic [NB_DMEM_ADDR-1:0] i_addr,
    input  logic [LEN-1:0]          i_wdata,
`ifdef DMEM_DEBUG_PORT_EN
    input  logic [NB_DMEM_ADDR-1:0] i_debug_addr,
    output logic [LEN-1:0]          o_debug_data,
`endif
    output logic [LEN-1:0]          o_rdata
);

    localparam int DEPTH = 1 << NB_DMEM_ADDR;

    genvar gi;
    generate
        for (gi = 0; gi < LEN/8; gi++) begin : g_lane
            logic [7:0] r_mem [0:DEPTH-1];

            always_ff @(posedge i_clk) begin
                if (i_we[gi]) begin
                    r_mem[i_addr] <= i_wdata[gi*8 +: 8];
                end
            end

            assign o_rdata[gi*8 +: 8] = r_mem[i_addr];
`ifdef DMEM_DEBUG_PORT_EN
            assign o_debug_data[gi*8 +: 8] = r_mem[i_debug_addr];
`endif
        end
    endgenerate

endmodule

// File: rtl/tl_memory.sv
// MEM stage: byte/half/word loads and stores into a private RAM, branch resolution,
// MEM forwarding and the negedge MEM/WB latch. Optional debug read port: DMEM_DEBUG_PORT_EN.
module tl_memory
    import tl_memory_pkg::*;
#(
    parameter int LEN                  = 32,
    parameter int NB_ADDRESS_REGISTROS = 5,
    parameter int NB_CTRL_WB           = 2,
    parameter int NB_CTRL_MEM          = 9,
    parameter int NB_DMEM_ADDR         = 8
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
`ifdef DMEM_DEBUG_PORT_EN
    input  logic [NB_DMEM_ADDR-1:0] i_debug_addr,
    output logic [LEN-1:0]          o_debug_data,
`endif
    tl_memory_if.slave              bus
);

    logic                    w_rd_en;
    logic                    w_wr_en;
    logic                    w_unsigned;
    size_e                   w_size;
    logic [1:0]              w_lane;
    logic                    w_mis;
    logic [NB_DMEM_ADDR-1:0] w_word_idx;
    logic [LEN/8-1:0]        w_be;
    logic [LEN/8-1:0]        w_we;
    logic [LEN-1:0]          w_wdata;
    logic [LEN-1:0]          w_rdata;
    logic [7:0]              w_byte;
    logic [15:0]             w_half;
    logic [LEN-1:0]          w_load;
    logic                    w_unused_bits;

    logic [LEN-1:0]                  r_rd_word;
    logic [LEN-1:0]                  r_read_data;
    logic [LEN-1:0]                  r_alu_result;
    logic [NB_ADDRESS_REGISTROS-1:0] r_write_reg;
    logic [NB_CTRL_WB-1:0]           r_ctrl_wb;
    logic                            r_misaligned;

    assign w_rd_en    = bus.i_ctrl_mem[MEMREAD];
    assign w_wr_en    = bus.i_ctrl_mem[MEMWRITE];
    assign w_unsigned = bus.i_ctrl_mem[UNSIGNED];
    assign w_size     = size_e'(bus.i_ctrl_mem[SIZE_HI:SIZE_LO]);
    assign w_lane     = bus.i_alu_result[1:0];
    assign w_word_idx = bus.i_alu_result[NB_DMEM_ADDR+1:2];
    assign w_mis      = is_misaligned(w_size, w_lane);

    assign w_unused_bits = ^{bus.i_alu_result[LEN-1:NB_DMEM_ADDR+2], bus.i_ctrl_mem[1:0]};

    always_comb begin
        w_be    = '1;
        w_wdata = bus.i_dato2;
        case (w_size)
            SZ_BYTE: begin
                w_be    = 4'b0001 << w_lane;
                w_wdata = {4{bus.i_dato2[7:0]}};
            end
            SZ_HALF: begin
                w_be    = w_lane[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{bus.i_dato2[15:0]}};
            end
            default: ;
        endcase
    end

    assign w_we = (w_wr_en && i_rst && !w_mis) ? w_be : '0;

    data_memory #(
        .LEN          (LEN),
        .NB_DMEM_ADDR (NB_DMEM_ADDR)
    ) u_data_memory (
        .i_clk        (i_clk),
        .i_we         (w_we),
        .i_addr       (w_word_idx),
        .i_wdata      (w_wdata),
`ifdef DMEM_DEBUG_PORT_EN
        .i_debug_addr (i_debug_addr),
        .o_debug_data (o_debug_data),
`endif
        .o_rdata      (w_rdata)
    );

    // Snapshot at the write edge so a simultaneous read+write returns the pre-write word.
    always_ff @(posedge i_clk) begin
        r_rd_word <= w_rdata;
    end

    always_comb begin
        w_byte = r_rd_word[7:0];
        case (w_lane)
            2'd1:    w_byte = r_rd_word[15:8];
            2'd2:    w_byte = r_rd_word[23:16];
            2'd3:    w_byte = r_rd_word[31:24];
            default: ;
        endcase
        w_half = w_lane[1] ? r_rd_word[31:16] : r_rd_word[15:0];
        w_load = r_rd_word;
        case (w_size)
            SZ_BYTE: w_load = w_unsigned ? {{(LEN-8){1'b0}}, w_byte}
                                         : {{(LEN-8){w_byte[7]}}, w_byte};
            SZ_HALF: w_load = w_unsigned ? {{(LEN-16){1'b0}}, w_half}
                                         : {{(LEN-16){w_half[15]}}, w_half};
            default: ;
        endcase
        if (!w_rd_en || w_mis) begin
            w_load = '0;
        end
    end

    always_ff @(negedge i_clk) begin
        if (!i_rst) begin
            r_read_data  <= '0;
            r_alu_result <= '0;
            r_write_reg  <= '0;
            r_ctrl_wb    <= '0;
            r_misaligned <= 1'b0;
        end else begin
            r_read_data  <= w_load;
            r_alu_result <= bus.i_alu_result;
            r_write_reg  <= bus.i_write_reg;
            r_ctrl_wb    <= bus.i_ctrl_wb;
            r_misaligned <= r_misaligned | (w_mis & (w_rd_en | w_wr_en));
        end
    end

    assign bus.o_pc_src       = (bus.i_ctrl_mem[BEQ] & bus.i_alu_zero) |
                                (bus.i_ctrl_mem[BNE] & ~bus.i_alu_zero);
    assign bus.o_pc_branch    = bus.i_pc_branch;
    assign bus.o_rd_mem_corto = bus.i_alu_result;
    assign bus.o_read_data    = r_read_data;
    assign bus.o_alu_result   = r_alu_result;
    assign bus.o_write_reg    = r_write_reg;
    assign bus.o_ctrl_wb      = r_ctrl_wb;
    assign bus.o_misaligned   = r_misaligned;

endmodule

// File: tb/tb_tl_memory.sv
// Bench for tl_memory: directed EX/MEM vectors push expected MEM/WB values into a queue,
// a negedge monitor pops and compares; combinational outputs are checked as each vector is applied.
module tb_tl_memory;

    logic clk;
    logic rst;

    tl_memory_if #(.LEN(32), .NB_ADDRESS_REGISTROS(5), .NB_CTRL_WB(2), .NB_CTRL_MEM(9)) bus();

    tl_memory dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] rd;
        logic [31:0] alu;
        logic [4:0]  wr;
        logic [1:0]  wb;
        logic        mis;
        int          due;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad   = 0;
    int   ncyc  = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    // Monitor: the MEM/WB latch updates at negedge; compare once it has settled.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            ncyc++;
            #2;
            while (sb_q.size() > 0 && sb_q[0].due <= ncyc) begin
                e = sb_q.pop_front();
                check({e.name, "/rd"},  bus.o_read_data, e.rd);
                check({e.name, "/alu"}, bus.o_alu_result, e.alu);
                check({e.name, "/wr"},  {27'b0, bus.o_write_reg}, {27'b0, e.wr});
                check({e.name, "/wb"},  {30'b0, bus.o_ctrl_wb}, {30'b0, e.wb});
                check({e.name, "/mis"}, {31'b0, bus.o_misaligned}, {31'b0, e.mis});
                $display("txn %-10s rd=%h alu=%h wr=%0d wb=%b mis=%b", e.name,
                         bus.o_read_data, bus.o_alu_result, bus.o_write_reg,
                         bus.o_ctrl_wb, bus.o_misaligned);
            end
        end
    end

    // Apply one EX/MEM vector for a full cycle and record what MEM/WB must show at its end.
    task automatic issue(input string nm, input logic r, input logic [31:0] alu,
                         input logic [31:0] d2, input logic [4:0] wreg, input logic [1:0] wb,
                         input logic [8:0] cm, input logic zero, input logic exp_src,
                         input logic [31:0] exp_rd, input logic exp_mis);
        exp_t e;
        @(negedge clk);
        #1;
        rst              = r;
        bus.i_alu_result = alu;
        bus.i_dato2      = d2;
        bus.i_pc_branch  = 32'h0040_0080;
        bus.i_alu_zero   = zero;
        bus.i_write_reg  = wreg;
        bus.i_ctrl_wb    = wb;
        bus.i_ctrl_mem   = cm;
        e.name = nm;
        e.rd   = exp_rd;
        e.alu  = r ? alu : 32'h0;
        e.wr   = r ? wreg : 5'd0;
        e.wb   = r ? wb : 2'd0;
        e.mis  = exp_mis;
        e.due  = ncyc + 1;
        sb_q.push_back(e);
        #1;
        check({nm, "/fwd"},   bus.o_rd_mem_corto, alu);
        check({nm, "/pcsrc"}, {31'b0, bus.o_pc_src}, {31'b0, exp_src});
        check({nm, "/pcbr"},  bus.o_pc_branch, 32'h0040_0080);
    endtask

    // ctrl_mem encodings: RD=0x100 WR=0x080 BEQ=0x040 BNE=0x020 size<<3 UNS=0x004
    initial begin
        rst              = 1'b0;
        bus.i_alu_result = '0;
        bus.i_dato2      = '0;
        bus.i_pc_branch  = '0;
        bus.i_alu_zero   = 1'b0;
        bus.i_write_reg  = '0;
        bus.i_ctrl_wb    = '0;
        bus.i_ctrl_mem   = '0;

        //     name          rst alu          dato2        wr  wb     ctrl    z  src  rd           mis
        issue("rst0",       0, 32'h40,      32'hFFFFFFFF, 1, 2'b11, 9'h098, 0, 0, 32'h0,        0);
        issue("rst1",       0, 32'h40,      32'hFFFFFFFF, 1, 2'b11, 9'h098, 0, 0, 32'h0,        0);
        issue("sw40",       1, 32'h40,      32'h11223344, 0, 2'b00, 9'h098, 0, 0, 32'h0,        0);
        issue("sw10",       1, 32'h10,      32'hDEADBEEF, 0, 2'b00, 9'h098, 0, 0, 32'h0,        0);
        issue("lw10",       1, 32'h10,      32'h0,        3, 2'b11, 9'h118, 0, 0, 32'hDEADBEEF, 0);
        issue("sw20",       1, 32'h20,      32'h0,        0, 2'b00, 9'h098, 0, 0, 32'h0,        0);
        issue("sb21",       1, 32'h21,      32'h12345680, 0, 2'b00, 9'h080, 0, 0, 32'h0,        0);
        issue("lb21",       1, 32'h21,      32'h0,        4, 2'b11, 9'h100, 0, 0, 32'hFFFFFF80, 0);
        issue("lbu21",      1, 32'h21,      32'h0,        4, 2'b11, 9'h104, 0, 0, 32'h00000080, 0);
        issue("lw20",       1, 32'h20,      32'h0,        4, 2'b11, 9'h118, 0, 0, 32'h00008000, 0);
        issue("sw30",       1, 32'h30,      32'hAABBCCDD, 0, 2'b00, 9'h098, 0, 0, 32'h0,        0);
        issue("sh32",       1, 32'h32,      32'hFFFF1234, 0, 2'b00, 9'h088, 0, 0, 32'h0,        0);
        issue("lh32",       1, 32'h32,      32'h0,        5, 2'b11, 9'h108, 0, 0, 32'h00001234, 0);
        issue("lh30",       1, 32'h30,      32'h0,        5, 2'b11, 9'h108, 0, 0, 32'hFFFFCCDD, 0);
        issue("lhu30",      1, 32'h30,      32'h0,        5, 2'b11, 9'h10C, 0, 0, 32'h0000CCDD, 0);
        issue("lh33mis",    1, 32'h33,      32'h0,        5, 2'b11, 9'h108, 0, 0, 32'h0,        1);
        issue("sw31mis",    1, 32'h31,      32'hFFFFFFFF, 0, 2'b00, 9'h098, 0, 0, 32'h0,        1);
        issue("lw30",       1, 32'h30,      32'h0,        6, 2'b11, 9'h118, 0, 0, 32'h1234CCDD, 1);
        issue("rdwr10",     1, 32'h10,      32'h55667788, 6, 2'b11, 9'h198, 0, 0, 32'hDEADBEEF, 1);
        issue("lw10b",      1, 32'h10,      32'h0,        6, 2'b11, 9'h118, 0, 0, 32'h55667788, 1);
        issue("lwrsv10",    1, 32'h10,      32'h0,        6, 2'b11, 9'h110, 0, 0, 32'h55667788, 1);
        issue("lwwrap",     1, 32'h410,     32'h0,        6, 2'b11, 9'h118, 0, 0, 32'h55667788, 1);
        issue("rst2",       0, 32'h40,      32'hFFFFFFFF, 2, 2'b11, 9'h098, 0, 0, 32'h0,        0);
        issue("rst3",       0, 32'h40,      32'hFFFFFFFF, 2, 2'b11, 9'h098, 0, 0, 32'h0,        0);
        issue("lw40",       1, 32'h40,      32'h0,        8, 2'b11, 9'h118, 0, 0, 32'h11223344, 0);
        issue("alu55",      1, 32'h55,      32'h0,        7, 2'b10, 9'h000, 0, 0, 32'h0,        0);
        issue("beq_z1",     1, 32'h0,       32'h0,        0, 2'b00, 9'h040, 1, 1, 32'h0,        0);
        issue("bne_z1",     1, 32'h0,       32'h0,        0, 2'b00, 9'h020, 1, 0, 32'h0,        0);
        issue("bne_z0",     1, 32'h1,       32'h0,        0, 2'b00, 9'h020, 0, 1, 32'h0,        0);
        issue("beq_z0",     1, 32'h1,       32'h0,        0, 2'b00, 9'h040, 0, 0, 32'h0,        0);

        repeat (3) @(negedge clk);
        #3;
        if (sb_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain actual=%0d required=0 pending", sb_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tl_memory.md
# tl_memory

MEM stage of the 5-stage MIPS pipeline, sitting between the EX/MEM latch and the write-back stage. It consumes the EX stage's registered result (ALU result, store data, branch target, zero flag, MEM/WB control), performs byte/half/word loads and stores into a private data RAM, resolves the branch decision back to fetch, drives the MEM-side forwarding value, and registers the MEM/WB pipeline latch.

## Interface
Parameters:
- LEN, 32, datapath width
- NB_ADDRESS_REGISTROS, 5, register-file address width
- NB_CTRL_WB, 2, WB control width: [1] RegWrite, [0] MemtoReg
- NB_CTRL_MEM, 9, MEM control width
- NB_DMEM_ADDR, 8, word-address width of data RAM (256 words)

Ports:
- i_clk  in  1  pipeline clock
- i_rst  in  1  reset, synchronous, active-low
- i_alu_result  in  LEN  byte address / ALU result from EX/MEM
- i_dato2  in  LEN  store data (rt)
- i_pc_branch  in  LEN  branch target
- i_alu_zero  in  1  ALU zero flag
- i_write_reg  in  NB_ADDRESS_REGISTROS  destination register
- i_ctrl_wb  in  NB_CTRL_WB  WB control
- i_ctrl_mem  in  NB_CTRL_MEM  [8] MemRead, [7] MemWrite, [6] BEQ, [5] BNE, [4:3] size (00 byte, 01 half, 11 word, 10 reserved=word), [2] unsigned load, [1:0] reserved
- o_pc_src  out  1  take branch (combinational)
- o_pc_branch  out  LEN  branch target to IF (combinational passthrough)
- o_rd_mem_corto  out  LEN  MEM forwarding value = i_alu_result (combinational)
- o_read_data  out  LEN  MEM/WB: extended load data
- o_alu_result  out  LEN  MEM/WB: ALU result
- o_write_reg  out  NB_ADDRESS_REGISTROS  MEM/WB: destination register
- o_ctrl_wb  out  NB_CTRL_WB  MEM/WB: WB control
- o_misaligned  out  1  sticky misaligned-access flag

## Operation
- Word index = i_alu_result[NB_DMEM_ADDR+1:2]; higher address bits ignored (wrap).
- Store (MemWrite=1, i_rst=1): byte writes i_dato2[7:0] into lane addr[1:0]; half writes i_dato2[15:0] into lanes {addr[1],1}/{addr[1],0}; word writes all 4 lanes. Little-endian.
- Load (MemRead=1): byte/half lane selected as above, sign-extended, zero-extended if bit [2]=1; word unchanged. MemRead=0 -> o_read_data latched as 0.
- Misaligned: half with addr[0]=1 or word with addr[1:0]!=0 -> store suppressed, load returns 0, o_misaligned set; cleared only by reset.
- MemRead and MemWrite both 1: write performed, read returns pre-write data.
- o_pc_src = (BEQ & i_alu_zero) | (BNE & ~i_alu_zero).
- RAM contents not reset; all registered outputs reset to 0.

## Timing
- RAM write on posedge i_clk; read path combinational from RAM.
- MEM/WB latch and o_misaligned update on negedge i_clk, consistent with EX/MEM latch.
- Reset sampled at negedge: o_read_data, o_alu_result, o_write_reg, o_ctrl_wb, o_misaligned <= 0. While i_rst=0, RAM writes are blocked.
- Load-use through memory: store presented in cycle N (write at its posedge) is visible to a load presented in cycle N+1.
- Load data reaches o_read_data at the negedge ending the cycle in which the load is presented (one cycle latency EX/MEM -> MEM/WB).
- o_pc_src, o_pc_branch, o_rd_mem_corto have zero latency.

## Configuration
- DMEM_DEBUG_PORT_EN defined: extra ports i_debug_addr (in, NB_DMEM_ADDR) and o_debug_data (out, LEN), asynchronous word read for the debug unit; no effect on pipeline behaviour.
- Undefined: ports absent, no extra read logic.

## Structure
- Shared package: ctrl_mem bit positions (MEMREAD, MEMWRITE, BEQ, BNE, SIZE_HI/LO, UNSIGNED), size encodings, ctrl_wb bit positions.
- One sub-module: data_memory (byte-lane write-enable RAM, async read, optional debug port).

## Test plan
- Reset: i_rst=0 across two negedges with MemWrite=1 -> all outputs 0, RAM word unchanged.
- SW 0xDEADBEEF to addr 0x10, then LW addr 0x10 -> o_read_data=0xDEADBEEF next negedge.
- SB 0x80 to addr 0x21; LB addr 0x21 -> 0xFFFFFF80; LBU -> 0x00000080; LW addr 0x20 shows 0x80 in bits [15:8].
- SH 0x1234 to addr 0x32; LH addr 0x33 -> o_read_data=0, o_misaligned=1, word at 0x30 unchanged except lanes 2-3 = 0x1234.
- BEQ with zero=1 -> o_pc_src=1, o_pc_branch=i_pc_branch; BNE with zero=1 -> o_pc_src=0.
- Non-memory op, i_alu_result=0x55, i_write_reg=7, ctrl_wb=2'b10 -> o_rd_mem_corto=0x55 immediately; MEM/WB outputs 0x55/7/2'b10, o_read_data=0 at negedge.
